// File: rtl/pwr_cntr_reader.sv
// pwr_cntr_reader: per-class toggle counters served through a single-outstanding read port.
// Define PWR_CNTR_SAT_EN for saturating counters; otherwise counters wrap.
module pwr_cntr_reader #(
  parameter int NUM_CNTR = 4,
  parameter int PROBE_W  = 8,
  parameter int CNTR_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         cnt_en,
  input  logic [NUM_CNTR*PROBE_W-1:0]  probe,
  input  logic                         rd_req,
  input  logic [3:0]                   rd_addr,
  output logic                         rd_busy,
  output logic                         rd_valid,
  output logic [CNTR_W-1:0]            rd_data,
  output logic                         rd_err,
  output logic                         rd_ovf
);
  localparam int IW = $clog2(PROBE_W + 1);
  typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;
  state_t state, state_nxt;
  logic [NUM_CNTR*PROBE_W-1:0] prev;
  logic prime, acc, sel_ovf;
  logic [3:0] addr_q;
  logic [NUM_CNTR-1:0] ovf;
  logic [CNTR_W-1:0] sel_cnt;
  logic [CNTR_W-1:0] cnt     [NUM_CNTR];
  logic [CNTR_W-1:0] cnt_nxt [NUM_CNTR];
  logic [CNTR_W:0]   sum     [NUM_CNTR];
  logic [IW-1:0]     inc     [NUM_CNTR];
  assign acc = cnt_en && prime;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (rd_req ? CAPT : IDLE) : state == CAPT ? RESP : IDLE;
  always_comb begin
    rd_busy  = state != IDLE;
    rd_valid = state == RESP;
  end
  // Out-of-range addresses match no counter, so the mux yields data 0 / ovf 0.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      inc[i] = '0;
      for (int b = 0; b < PROBE_W; b++)
        inc[i] = inc[i] + IW'(probe[i*PROBE_W+b] ^ prev[i*PROBE_W+b]);
      sum[i] = {1'b0, cnt[i]} + (CNTR_W+1)'(inc[i]);
`ifdef PWR_CNTR_SAT_EN
      cnt_nxt[i] = sum[i][CNTR_W] ? '1 : sum[i][CNTR_W-1:0];
`else
      cnt_nxt[i] = sum[i][CNTR_W-1:0];
`endif
      if (addr_q == 4'(i)) begin
        sel_cnt = cnt[i];
        sel_ovf = ovf[i];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      prev    <= '0;
      prime   <= 1'b0;
      addr_q  <= '0;
      rd_data <= '0;
      rd_err  <= 1'b0;
      rd_ovf  <= 1'b0;
      ovf     <= '0;
      for (int i = 0; i < NUM_CNTR; i++) cnt[i] <= '0;
    end else begin
      prev  <= probe;
      prime <= 1'b1;
      if (state == IDLE && rd_req) addr_q <= rd_addr;
      if (state == CAPT) begin
        rd_data <= sel_cnt;
        rd_err  <= int'(addr_q) >= NUM_CNTR;
        rd_ovf  <= sel_ovf;
      end
      // The read clears the counter but keeps the increment landing on the same edge.
      for (int i = 0; i < NUM_CNTR; i++)
        if (state == CAPT && addr_q == 4'(i)) begin
          cnt[i] <= acc ? CNTR_W'(inc[i]) : '0;
          ovf[i] <= 1'b0;
        end else if (acc) begin
          cnt[i] <= cnt_nxt[i];
          ovf[i] <= ovf[i] | sum[i][CNTR_W];
        end
    end
endmodule

// File: tb/tb_pwr_cntr_reader.sv
// tb_pwr_cntr_reader: directed checks of counting, read handshake, range error, overflow and reset abort.
module tb_pwr_cntr_reader;
  logic clk = 1'b0, reset_L = 1'b0, cnt_en = 1'b0, rd_req = 1'b0;
  logic [31:0] probe = '0;
  logic [3:0] rd_addr = '0;
  logic rd_busy, rd_valid, rd_err, rd_ovf;
  logic [15:0] rd_data;
  logic rd_busy4, rd_valid4, rd_err4, rd_ovf4;
  logic [3:0] rd_data4;
  int n_cmp = 0, n_err = 0;
  logic [15:0] d;
  logic e, o;
  logic [3:0] vp, bp;

  always #5 clk = ~clk;

  pwr_cntr_reader u_dut (
    .clk(clk), .reset_L(reset_L), .cnt_en(cnt_en), .probe(probe),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .rd_ovf(rd_ovf));

  pwr_cntr_reader #(.CNTR_W(4)) u_dut4 (
    .clk(clk), .reset_L(reset_L), .cnt_en(cnt_en), .probe(probe),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy4), .rd_valid(rd_valid4),
    .rd_data(rd_data4), .rd_err(rd_err4), .rd_ovf(rd_ovf4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a read; cp is driven onto probe during the CAPT cycle, hold keeps rd_req high through CAPT.
  task automatic rd(input logic [3:0] a, input logic [31:0] cp, input bit hold,
                    output logic [15:0] rdat, output logic rerr, output logic rovf,
                    output logic [3:0] vpat, output logic [3:0] bpat);
    rd_addr = a;
    rd_req  = 1'b1;
    tick;
    vpat[0] = rd_valid; bpat[0] = rd_busy;
    probe = cp;
    if (!hold) rd_req = 1'b0;
    tick;
    vpat[1] = rd_valid; bpat[1] = rd_busy;
    rd_req = 1'b0;
    rdat = rd_data; rerr = rd_err; rovf = rd_ovf;
    tick;
    vpat[2] = rd_valid; bpat[2] = rd_busy;
    tick;
    vpat[3] = rd_valid; bpat[3] = rd_busy;
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_busy", rd_busy, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_ovf", rd_ovf, 0);
    reset_L = 1'b1;
    cnt_en  = 1'b1;
    repeat (10) tick;
    rd(4'd0, probe, 0, d, e, o, vp, bp);
    chk("idle_data", d, 0);
    chk("idle_err", e, 0);
    chk("idle_valid_pat", vp, 4'b0010);
    chk("idle_busy_pat", bp, 4'b0011);

    for (int j = 0; j < 5; j++) begin
      probe[15:8] ^= 8'hFF;
      tick;
    end
    rd(4'd1, probe, 0, d, e, o, vp, bp);
    chk("c1_40", d, 40);
    rd(4'd1, probe, 0, d, e, o, vp, bp);
    chk("c1_reread", d, 0);

    probe[20:16] = 5'h1F;
    tick;
    rd(4'd2, probe ^ 32'h00E0_0000, 0, d, e, o, vp, bp);
    chk("c2_excl", d, 5);
    rd(4'd2, probe, 0, d, e, o, vp, bp);
    chk("c2_kept", d, 3);

    probe[25:24] = 2'b11;
    probe[0] = 1'b1;
    tick;
    rd(4'd7, probe, 0, d, e, o, vp, bp);
    chk("oor_err", e, 1);
    chk("oor_data", d, 0);
    chk("oor_ovf", o, 0);
    rd(4'd3, probe, 1, d, e, o, vp, bp);
    chk("c3_after_oor", d, 2);
    chk("hold_req_valid_pat", vp, 4'b0010);
    chk("hold_req_busy_pat", bp, 4'b0011);
    rd(4'd0, probe, 0, d, e, o, vp, bp);
    chk("c0_after_oor", d, 1);
    chk("c0_err", e, 0);

    probe[15:8] = 8'h00;
    tick;
    rd_addr = 4'd1;
    rd_req  = 1'b1;
    tick;
    rd_req = 1'b0;
    tick;
    chk("abort_resp_valid", rd_valid, 1);
    chk("abort_resp_data", rd_data, 8);
    reset_L = 1'b0;
    #1;
    chk("abort_valid", rd_valid, 0);
    chk("abort_busy", rd_busy, 0);
    chk("abort_data", rd_data, 0);
    chk("abort_err", rd_err, 0);
    chk("abort_ovf", rd_ovf, 0);
    tick;
    tick;
    reset_L = 1'b1;
    repeat (2) tick;
    rd(4'd1, probe, 0, d, e, o, vp, bp);
    chk("post_rst_c1", d, 0);

    for (int j = 0; j < 20; j++) begin
      probe[0] ^= 1'b1;
      tick;
    end
    rd(4'd0, probe, 0, d, e, o, vp, bp);
    chk("w16_data", d, 20);
    chk("w16_ovf", o, 0);
`ifdef PWR_CNTR_SAT_EN
    chk("w4_data", rd_data4, 15);
`else
    chk("w4_data", rd_data4, 4);
`endif
    chk("w4_ovf", rd_ovf4, 1);
    rd(4'd0, probe, 0, d, e, o, vp, bp);
    chk("w4_reread_data", rd_data4, 0);
    chk("w4_reread_ovf", rd_ovf4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
